// File: rtl/mmult_opt_mdc_tcdm_rr_mux_pkg.sv
// Shared types and defaults for the mmult_opt_mdc TCDM round-robin request mux.
package mmult_opt_mdc_package;

    localparam int TCDM_MUX_MP         = 3;
    localparam int TCDM_MUX_NB_OUTSTND = 4;
    localparam int TCDM_MUX_AW         = 32;
    localparam int TCDM_MUX_DW         = 32;

    typedef logic [$clog2(TCDM_MUX_MP)-1:0] port_idx_t;

    typedef struct packed {
        logic [TCDM_MUX_AW-1:0]   add;
        logic                     wen;
        logic [TCDM_MUX_DW/8-1:0] be;
        logic [TCDM_MUX_DW-1:0]   data;
    } tcdm_req_t;

endpackage

// File: rtl/mmult_opt_mdc_tcdm_rr_mux_id_fifo.sv
// In-order FIFO of issuing-port indices; one entry per granted, not yet answered transaction.
module hwpe_tcdm_id_fifo
    import mmult_opt_mdc_package::*;
#(
    parameter int  DEPTH  = TCDM_MUX_NB_OUTSTND,
    parameter type elem_t = port_idx_t,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push,
    input  elem_t         push_data,
    input  logic          pop,
    output elem_t         head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    elem_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt;
    logic           push_ok, pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; an entry is only read after it was written, so reset adds nothing.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/mmult_opt_mdc_tcdm_rr_mux.sv
// Merges MP TCDM master ports into one with round-robin arbitration and in-order response routing.
module mmult_opt_mdc_tcdm_rr_mux
    import mmult_opt_mdc_package::*;
#(
    parameter int  MP         = TCDM_MUX_MP,
    parameter int  NB_OUTSTND = TCDM_MUX_NB_OUTSTND,
    parameter int  AW         = TCDM_MUX_AW,
    parameter int  DW         = TCDM_MUX_DW,
    localparam int CW         = $clog2(NB_OUTSTND) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [MP-1:0]                in_req,
    output logic [MP-1:0]                in_gnt,
    input  logic [MP-1:0][AW-1:0]        in_add,
    input  logic [MP-1:0]                in_wen,
    input  logic [MP-1:0][DW/8-1:0]      in_be,
    input  logic [MP-1:0][DW-1:0]        in_data,
    output logic [MP-1:0][DW-1:0]        in_r_data,
    output logic [MP-1:0]                in_r_valid,
    output logic                         out_req,
    input  logic                         out_gnt,
    output logic [AW-1:0]                out_add,
    output logic                         out_wen,
    output logic [DW/8-1:0]              out_be,
    output logic [DW-1:0]                out_data,
    input  logic [DW-1:0]                out_r_data,
    input  logic                         out_r_valid,
    output logic [CW-1:0]                outstanding_o,
    output logic                         err_o
);

    localparam int IW = $clog2(MP);
    typedef logic [IW-1:0] idx_t;

    idx_t      rr_ptr, sel, head;
    logic      found, full, empty, accept, pop;
    tcdm_req_t sel_req;

    // Round-robin scan starting at rr_ptr; the first requester wins.
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < MP; i++) begin
            if (!found && in_req[(int'(rr_ptr) + i) % MP]) begin
                sel   = idx_t'((int'(rr_ptr) + i) % MP);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_req.add  = in_add[sel];
        sel_req.wen  = in_wen[sel];
        sel_req.be   = in_be[sel];
        sel_req.data = in_data[sel];
    end

    // A full FIFO blocks new requests even if it pops this cycle, keeping full off the pop path.
    assign out_req  = (|in_req) && !full;
    assign accept   = out_req && out_gnt;
    assign out_add  = sel_req.add;
    assign out_wen  = sel_req.wen;
    assign out_be   = sel_req.be;
    assign out_data = sel_req.data;

    always_comb begin
        in_gnt      = '0;
        in_gnt[sel] = accept;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (clear_i) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (sel == idx_t'(MP - 1)) ? '0 : sel + 1'b1;
        end
    end

    assign pop = out_r_valid && !empty;

    always_comb begin
        for (int k = 0; k < MP; k++) begin
            in_r_valid[k] = pop && (head == idx_t'(k));
            in_r_data[k]  = out_r_data;
        end
    end

    // Sticky flag for a response that has no matching transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (clear_i) begin
            err_o <= 1'b0;
        end else if (out_r_valid && empty) begin
            err_o <= 1'b1;
        end
    end

    hwpe_tcdm_id_fifo #(
        .DEPTH  (NB_OUTSTND),
        .elem_t (idx_t)
    ) i_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .push      (accept),
        .push_data (sel),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (outstanding_o)
    );

endmodule

// File: tb/tb_mmult_opt_mdc_tcdm_rr_mux.sv
// Directed bench with a response scoreboard for the TCDM round-robin mux.
module tb_mmult_opt_mdc_tcdm_rr_mux;

    localparam int MP = 3;
    localparam int NB = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = $clog2(NB) + 1;

    logic                    clk = 1'b0;
    logic                    rst_ni;
    logic                    clear_i;
    logic [MP-1:0]           in_req;
    logic [MP-1:0]           in_gnt;
    logic [MP-1:0][AW-1:0]   in_add;
    logic [MP-1:0]           in_wen;
    logic [MP-1:0][DW/8-1:0] in_be;
    logic [MP-1:0][DW-1:0]   in_data;
    logic [MP-1:0][DW-1:0]   in_r_data;
    logic [MP-1:0]           in_r_valid;
    logic                    out_req;
    logic                    out_gnt;
    logic [AW-1:0]           out_add;
    logic                    out_wen;
    logic [DW/8-1:0]         out_be;
    logic [DW-1:0]           out_data;
    logic [DW-1:0]           out_r_data;
    logic                    out_r_valid;
    logic [CW-1:0]           outstanding_o;
    logic                    err_o;

    always #5 clk = ~clk;

    mmult_opt_mdc_tcdm_rr_mux #(.MP(MP), .NB_OUTSTND(NB), .AW(AW), .DW(DW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .in_req        (in_req),
        .in_gnt        (in_gnt),
        .in_add        (in_add),
        .in_wen        (in_wen),
        .in_be         (in_be),
        .in_data       (in_data),
        .in_r_data     (in_r_data),
        .in_r_valid    (in_r_valid),
        .out_req       (out_req),
        .out_gnt       (out_gnt),
        .out_add       (out_add),
        .out_wen       (out_wen),
        .out_be        (out_be),
        .out_data      (out_data),
        .out_r_data    (out_r_data),
        .out_r_valid   (out_r_valid),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mon_port;
    exp_t mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response seen on an upstream port is matched against the scoreboard head.
    always @(negedge clk) begin
        if (|in_r_valid) begin
            mon_port = 0;
            for (int k = 0; k < MP; k++) if (in_r_valid[k]) mon_port = k;
            check("resp_onehot", 64'($countones(in_r_valid)), 64'd1);
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(in_r_valid), 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("resp_port", 64'(mon_port), 64'(mon_exp.port));
                check("resp_data", 64'(in_r_data[mon_port]), 64'(mon_exp.data));
            end
        end
    end

    task automatic drive(input logic [MP-1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        in_req      = req;
        out_gnt     = gnt;
        out_r_valid = rv;
        out_r_data  = rd;
    endtask

    task automatic expect_resp(input int port, input logic [31:0] data);
        sb.push_back('{port, data});
        drive('0, 1'b0, 1'b1, data);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [MP-1:0] stall_gnt [4];
    int            drain_port [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stall_gnt  = '{3'b100, 3'b001, 3'b010, 3'b100};
        drain_port = '{0, 1, 2, 0};
        for (int k = 0; k < MP; k++) begin
            in_add[k]  = 32'h1000 + k;
            in_wen[k]  = k[0];
            in_be[k]   = 4'h1 << k;
            in_data[k] = 32'hCAFE_0000 + k;
        end
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        drive('0, 1'b0, 1'b0, '0);

        #12;
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_gnt", 64'(in_gnt), 64'd0);
        check("rst_out_req", 64'(out_req), 64'd0);
        check("rst_r_valid", 64'(in_r_valid), 64'd0);
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // Fairness: all ports request, one-cycle response latency.
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, 1'b1, c > 0, 32'hD0 + c);
            if (c > 0) sb.push_back('{(c - 1) % 3, 32'hD0 + c});
            @(negedge clk);
            check("fair_gnt", 64'(in_gnt), 64'(3'b001 << (c % 3)));
            check("fair_add", 64'(out_add), 64'(32'h1000 + c % 3));
            check("fair_cnt", 64'(outstanding_o), 64'(c > 0));
            next_cycle();
        end
        sb.push_back('{2, 32'hD6});
        drive('0, 1'b1, 1'b1, 32'hD6);
        @(negedge clk);
        check("fair_idle_req", 64'(out_req), 64'd0);
        next_cycle();
        drive('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("fair_drained", 64'(outstanding_o), 64'd0);
        next_cycle();

        // Sparse: port 2 alone wraps rr_ptr to 0, then port 0 beats port 1, then port 1 alone.
        drive(3'b100, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("sparse_gnt2", 64'(in_gnt), 64'(3'b100));
        check("sparse_data2", 64'(out_data), 64'(32'hCAFE_0002));
        check("sparse_be2", 64'(out_be), 64'(4'h4));
        next_cycle();
        sb.push_back('{2, 32'h22});
        drive(3'b011, 1'b1, 1'b1, 32'h22);
        @(negedge clk);
        check("sparse_wrap_gnt0", 64'(in_gnt), 64'(3'b001));
        next_cycle();
        sb.push_back('{0, 32'h20});
        drive(3'b010, 1'b1, 1'b1, 32'h20);
        @(negedge clk);
        check("sparse_gnt1", 64'(in_gnt), 64'(3'b010));
        check("sparse_wen1", 64'(out_wen), 64'd1);
        next_cycle();
        expect_resp(1, 32'h21);
        next_cycle();
        drive('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("sparse_drained", 64'(outstanding_o), 64'd0);
        next_cycle();

        // Full stall: four accepts with no responses, then a single response.
        for (int c = 0; c < 4; c++) begin
            drive(3'b111, 1'b1, 1'b0, '0);
            @(negedge clk);
            check("stall_gnt", 64'(in_gnt), 64'(stall_gnt[c]));
            next_cycle();
        end
        drive(3'b111, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("full_out_req", 64'(out_req), 64'd0);
        check("full_gnt", 64'(in_gnt), 64'd0);
        check("full_cnt", 64'(outstanding_o), 64'd4);
        next_cycle();
        sb.push_back('{2, 32'h30});
        drive(3'b111, 1'b1, 1'b1, 32'h30);
        @(negedge clk);
        check("full_no_bypass", 64'(out_req), 64'd0);
        check("full_pop_gnt", 64'(in_gnt), 64'd0);
        next_cycle();
        drive(3'b111, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("refill_cnt", 64'(outstanding_o), 64'd3);
        check("refill_out_req", 64'(out_req), 64'd1);
        check("refill_gnt", 64'(in_gnt), 64'(3'b001));
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            expect_resp(drain_port[c], 32'h31 + c);
            next_cycle();
        end
        drive('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("stall_drained", 64'(outstanding_o), 64'd0);
        next_cycle();

        // In-order return with varying gaps: grants to 1,0,2.
        drive(3'b010, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("ord_gnt1", 64'(in_gnt), 64'(3'b010));
        next_cycle();
        drive(3'b001, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("ord_gnt0", 64'(in_gnt), 64'(3'b001));
        next_cycle();
        drive(3'b100, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("ord_gnt2", 64'(in_gnt), 64'(3'b100));
        next_cycle();
        expect_resp(1, 32'hA1);
        next_cycle();
        drive('0, 1'b0, 1'b0, '0);
        next_cycle();
        expect_resp(0, 32'hB0);
        next_cycle();
        expect_resp(2, 32'hC2);
        next_cycle();
        drive('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("ord_drained", 64'(outstanding_o), 64'd0);
        check("ord_sb_empty", 64'(sb.size()), 64'd0);
        next_cycle();

        // Spurious response with an empty FIFO, then soft clear.
        drive('0, 1'b0, 1'b1, 32'hDEAD);
        @(negedge clk);
        check("spur_r_valid", 64'(in_r_valid), 64'd0);
        check("spur_err_before", 64'(err_o), 64'd0);
        next_cycle();
        drive('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("spur_err_set", 64'(err_o), 64'd1);
        next_cycle();
        clear_i = 1'b1;
        @(negedge clk);
        check("clear_err_hold", 64'(err_o), 64'd1);
        next_cycle();
        clear_i = 1'b0;
        @(negedge clk);
        check("clear_err", 64'(err_o), 64'd0);
        next_cycle();

        // Asynchronous reset with two transactions in flight.
        drive(3'b111, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("rst_flight_gnt0", 64'(in_gnt), 64'(3'b001));
        next_cycle();
        @(negedge clk);
        check("rst_flight_gnt1", 64'(in_gnt), 64'(3'b010));
        next_cycle();
        drive('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("rst_flight_cnt", 64'(outstanding_o), 64'd2);
        #1;
        rst_ni = 1'b0;
        out_r_valid = 1'b1;
        out_r_data  = 32'hBAD;
        #1;
        check("async_rst_cnt", 64'(outstanding_o), 64'd0);
        check("async_rst_gnt", 64'(in_gnt), 64'd0);
        check("async_rst_r_valid", 64'(in_r_valid), 64'd0);
        check("async_rst_err", 64'(err_o), 64'd0);
        #1;
        out_r_valid = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
